// File: rtl/cache_refill_arbiter.sv
// -----------------------------------------------------------------------------
// cache_refill_arbiter
//
// Shares one memory read port between the I-cache and D-cache miss paths.
// A round-robin arbiter picks one requester, issues a single line-aligned read
// address, then counts BEATS refill beats and steers them to the winner. The
// final beat is flagged with rlast so the cache FSM can leave its MISS state.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   i_req / i_addr          I-cache miss request (held until i_gnt) and address
//   i_gnt                   one-cycle pulse, I-cache request accepted
//   i_rvalid / i_rlast      refill beat valid / final beat for the I-cache
//   d_req / d_addr          D-cache miss request (held until d_gnt) and address
//   d_gnt                   one-cycle pulse, D-cache request accepted
//   d_rvalid / d_rlast      refill beat valid / final beat for the D-cache
//   rdata                   refill data shared by both caches (= m_rdata)
//   m_arvalid / m_araddr    memory read-address valid / line-aligned address
//   m_arready               memory accepts the address
//   m_rvalid / m_rdata      memory data beat valid / data
//   busy                    high whenever a transfer is in progress
// -----------------------------------------------------------------------------
module cache_refill_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BEATS      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic                  i_rlast,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic                  d_rlast,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_arvalid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  busy
);

  // Byte-offset bits within one cache line; these are zeroed in m_araddr.
  localparam int LOFF = $clog2(BEATS * DATA_WIDTH / 8);
  localparam int BW   = $clog2(BEATS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t                state;
  state_t                state_nxt;
  owner_t                owner;
  owner_t                last_owner;
  logic                  gnt_q;
  logic [BW-1:0]         beat;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic                  any_req;
  logic                  pick_d;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  beat_fire;
  logic                  last_beat;

  // Round-robin: a lone request wins; on a tie the side not served last wins.
  assign any_req   = i_req | d_req;
  assign pick_d    = d_req & (~i_req | (last_owner == OWN_I));
  assign sel_addr  = pick_d ? d_addr : i_addr;

  // Memory beats only count while in DATA; stray m_rvalid elsewhere is ignored.
  assign beat_fire = (state == S_DATA) & m_rvalid;
  assign last_beat = beat_fire & (beat == BW'(BEATS - 1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaulting every output of a combinational block before the case
    // guarantees no path leaves it unassigned, so no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req)   state_nxt = S_ADDR;
      S_ADDR:  if (m_arready) state_nxt = S_DATA;
      S_DATA:  if (last_beat) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement or process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Owner, address latch, grant pulse and beat counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= OWN_I;
      last_owner <= OWN_D;   // so the I-cache wins the first tie
      gnt_q      <= 1'b0;
      beat       <= '0;
      addr_q     <= '0;
    end else begin
      // Grant is high only for the first ADDR cycle, regardless of m_arready.
      gnt_q <= (state == S_IDLE) & any_req;

      if ((state == S_IDLE) && any_req) begin
        owner  <= pick_d ? OWN_D : OWN_I;
        addr_q <= {sel_addr[ADDR_WIDTH-1:LOFF], LOFF'(0)};
      end

      if ((state == S_ADDR) && m_arready) beat <= '0;
      else if (beat_fire)                 beat <= beat + BW'(1);

      if (last_beat) last_owner <= owner;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign i_gnt     = gnt_q & (owner == OWN_I);
  assign d_gnt     = gnt_q & (owner == OWN_D);
  assign m_arvalid = (state == S_ADDR);
  assign m_araddr  = addr_q;
  assign busy      = (state != S_IDLE);

  // Beat steering is combinational so data reaches the cache with no latency.
  assign i_rvalid  = beat_fire & (owner == OWN_I);
  assign d_rvalid  = beat_fire & (owner == OWN_D);
  assign i_rlast   = last_beat & (owner == OWN_I);
  assign d_rlast   = last_beat & (owner == OWN_D);

  // Pure pass-through; the qualifying rvalid carries all the meaning.
  assign rdata     = m_rdata;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_arbiter
//
// Self-checking bench for cache_refill_arbiter. The stimulus thread plays the
// role of both caches and the memory; every beat it drives during a refill is
// pushed into a scoreboard queue with the owner and last flag it must carry.
// A negedge monitor pops an entry for each rvalid the DUT produces and compares.
// -----------------------------------------------------------------------------
module tb_cache_refill_arbiter;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int BEATS = 8;

  typedef struct {
    bit            own;   // 0 = I-cache, 1 = D-cache
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req;
  logic [AW-1:0] i_addr, d_addr;
  logic          i_gnt, d_gnt;
  logic          i_rvalid, d_rvalid, i_rlast, d_rlast;
  logic [DW-1:0] rdata;
  logic          m_arvalid, m_arready, m_rvalid;
  logic [AW-1:0] m_araddr;
  logic [DW-1:0] m_rdata;
  logic          busy;

  beat_t exp_q[$];
  int    n_tests   = 0;
  int    n_fail    = 0;
  int    i_gnt_cnt = 0;
  int    d_gnt_cnt = 0;
  int    i_beats   = 0;
  int    d_beats   = 0;

  cache_refill_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BEATS     (BEATS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rlast  (i_rlast),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rlast  (d_rlast),
    .rdata    (rdata),
    .m_arvalid(m_arvalid),
    .m_araddr (m_araddr),
    .m_arready(m_arready),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return {a[AW-1:6], 6'd0};
  endfunction

  // Monitor: sampled on the falling edge, half a cycle away from state changes.
  always @(negedge clk) begin
    beat_t e;
    if (i_gnt) i_gnt_cnt++;
    if (d_gnt) d_gnt_cnt++;
    if (i_rlast || d_rlast)
      check("rlast_needs_rvalid", {i_rlast, d_rlast} & ~{i_rvalid, d_rvalid}, 0);
    if (i_rvalid || d_rvalid) begin
      check("rvalid_onehot", i_rvalid & d_rvalid, 0);
      if (exp_q.size() == 0) begin
        check("beat_expected", {i_rvalid, d_rvalid}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("beat_owner", d_rvalid, e.own);
        check("beat_data", rdata, e.data);
        check("beat_last", e.own ? d_rlast : i_rlast, e.last);
      end
      if (i_rvalid) i_beats++;
      if (d_rvalid) d_beats++;
    end
  end

  // One miss: grant sample, address phase (optionally stalled), full refill.
  // Requests are set up by the caller; the winner's req is dropped on its gnt.
  task automatic run_miss(input bit own, input logic [AW-1:0] exp_addr,
                          input int ar_delay, input bit gaps, input bit spur);
    int            ib0, db0, ig0, dg0, beats, cyc;
    logic [DW-1:0] d;
    check("idle_busy", busy, 0);
    check("idle_gnt", {i_gnt, d_gnt}, 0);
    ig0 = i_gnt_cnt; dg0 = d_gnt_cnt; ib0 = i_beats; db0 = d_beats;
    m_rvalid = spur;
    tick();
    check("gnt_i", i_gnt, !own);
    check("gnt_d", d_gnt, own);
    check("arvalid", m_arvalid, 1);
    check("busy", busy, 1);
    check("araddr", m_araddr, exp_addr);
    if (own) d_req = 1'b0;
    else     i_req = 1'b0;
    for (int c = 0; c < ar_delay; c++) begin
      m_arready = 1'b0;
      m_rvalid  = spur;
      tick();
      check("ar_hold", m_arvalid, 1);
      check("ar_addr_hold", m_araddr, exp_addr);
      check("gnt_once", i_gnt | d_gnt, 0);
    end
    m_arready = 1'b1;
    m_rvalid  = spur;
    tick();
    m_arready = 1'b0;
    beats = 0;
    cyc   = 0;
    while (beats < BEATS) begin
      d = {$urandom, $urandom};
      m_rdata = d;
      if (!gaps || (cyc % 3 == 0)) begin
        m_rvalid = 1'b1;
        exp_q.push_back('{own: own, data: d, last: (beats == BEATS - 1)});
        beats++;
      end else begin
        m_rvalid = 1'b0;
      end
      cyc++;
      tick();
    end
    m_rvalid = spur;
    check("q_drained", exp_q.size(), 0);
    check("busy_after", busy, 0);
    check("arvalid_after", m_arvalid, 0);
    check("beats_i", i_beats - ib0, own ? 0 : BEATS);
    check("beats_d", d_beats - db0, own ? BEATS : 0);
    check("gnt_cnt_i", i_gnt_cnt - ig0, own ? 0 : 1);
    check("gnt_cnt_d", d_gnt_cnt - dg0, own ? 1 : 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    logic [DW-1:0] x;
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0;
    i_addr = '0; d_addr = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    repeat (2) tick();
    check("reset_outs", {i_gnt, d_gnt, i_rvalid, d_rvalid, i_rlast, d_rlast, m_arvalid, busy}, 0);
    check("reset_araddr", m_araddr, 0);
    reset = 1'b0;
    tick();

    // Single I miss, memory always ready.
    i_addr = 64'h1234; i_req = 1'b1;
    run_miss(1'b0, 64'h1200, 0, 1'b0, 1'b0);
    check("single_no_d", d_gnt_cnt + d_beats, 0);

    // Ties after reset alternate I, D, I, D with one dead cycle between bursts.
    apply_reset();
    i_addr = 64'h4000_0048; d_addr = 64'hABCD_EF7F;
    i_req = 1'b1; d_req = 1'b1;
    run_miss(1'b0, line_of(i_addr), 0, 1'b0, 1'b0);
    i_req = 1'b1;
    run_miss(1'b1, line_of(d_addr), 0, 1'b0, 1'b0);
    d_req = 1'b1;
    run_miss(1'b0, line_of(i_addr), 0, 1'b0, 1'b0);
    run_miss(1'b1, line_of(d_addr), 0, 1'b0, 1'b0);
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // Address phase stalled for 5 cycles.
    i_addr = 64'hFFFF_0000_0000_13C5; i_req = 1'b1;
    run_miss(1'b0, line_of(i_addr), 5, 1'b0, 1'b0);
    tick();

    // D refill with beat gaps 1,0,0,1,...
    d_addr = 64'h0000_0000_8000_003F; d_req = 1'b1;
    run_miss(1'b1, line_of(d_addr), 0, 1'b1, 1'b0);
    tick();

    // Spurious m_rvalid in IDLE and ADDR must neither show up nor count.
    m_rvalid = 1'b1;
    m_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
    repeat (2) tick();
    check("spur_idle_busy", busy, 0);
    i_addr = 64'h0000_0000_0000_0FC1; i_req = 1'b1;
    run_miss(1'b0, line_of(i_addr), 3, 1'b0, 1'b1);
    tick();
    m_rvalid = 1'b0;
    check("spur_after_idle", busy, 0);

    // Reset in the middle of DATA, after three beats.
    i_addr = 64'h0000_0000_0000_2A80; i_req = 1'b1;
    tick();
    check("rst_test_gnt", i_gnt, 1);
    i_req = 1'b0;
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      x = {$urandom, $urandom};
      m_rdata = x; m_rvalid = 1'b1;
      exp_q.push_back('{own: 1'b0, data: x, last: 1'b0});
      tick();
    end
    x = {$urandom, $urandom};
    m_rdata = x; m_rvalid = 1'b1;
    reset = 1'b1;
    #1;
    check("midrst_outs", {i_gnt, d_gnt, i_rvalid, d_rvalid, i_rlast, d_rlast, m_arvalid, busy}, 0);
    check("midrst_araddr", m_araddr, 0);
    check("rdata_passthru", rdata, x);
    check("midrst_q", exp_q.size(), 0);
    tick();
    m_rvalid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // last_owner was I before reset; a tie must still go to I first.
    i_addr = 64'h0000_0000_0000_5511; d_addr = 64'h0000_0000_0000_77C0;
    i_req = 1'b1; d_req = 1'b1;
    run_miss(1'b0, line_of(i_addr), 0, 1'b0, 1'b0);
    run_miss(1'b1, line_of(d_addr), 0, 1'b0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
